// File: rtl/arm_regfile_mp_if.sv
// Register-file access bundle: read ports, two write ports, PC redirect and NZCV flags.
// The decode/control side drives through master; the register file takes slave.
interface arm_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int N_RD   = 3
);
    logic [N_RD*ADDR_W-1:0] ra;
    logic [N_RD*DATA_W-1:0] rd;
    logic                   we0;
    logic [ADDR_W-1:0]      wa0;
    logic [DATA_W-1:0]      wd0;
    logic                   we1;
    logic [ADDR_W-1:0]      wa1;
    logic [DATA_W-1:0]      wd1;
    logic [DATA_W-1:0]      pc_in;
    logic                   pc_wr;
    logic [DATA_W-1:0]      pc_wd;
    logic [1:0]             flag_we;
    logic [3:0]             flags_in;
    logic [3:0]             flags;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, pc_in, flag_we, flags_in,
        input  rd, pc_wr, pc_wd, flags
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, pc_in, flag_we, flags_in,
        output rd, pc_wr, pc_wd, flags
    );
endinterface

// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: N_RD combinational read ports with write-first forwarding,
// two write ports (port 1 wins on collision), PC aliasing and split NZCV flag storage.
module arm_regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int N_RD      = 3,
    parameter int PC_REG    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic             clk,
    input  logic             reset,
    arm_regfile_mp_if.slave  bus
);
    localparam int N_ENT = 2 ** ADDR_W;

    generate
        if (N_RD < 1 || N_RD > 4) begin : g_bad_nrd
            $error("arm_regfile_mp: N_RD must be in 1..4");
        end
        if (PC_REG < 0 || PC_REG >= N_ENT) begin : g_bad_pcreg
            $error("arm_regfile_mp: PC_REG must index an entry of the file");
        end
    endgenerate

    logic [DATA_W-1:0] regs [N_ENT];
    logic [N_ENT-1:0]  hit0;
    logic [N_ENT-1:0]  hit1;
    logic [DATA_W-1:0] pc_rel;
    logic              pc_hit0;
    logic              pc_hit1;
    logic [N_RD*DATA_W-1:0] rd_all;
    logic [1:0]        nz;
    logic [1:0]        cv;

    // Read priority: PC alias, then port-1 forward, then port-0 forward, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] pc_val,
        input logic              we1,
        input logic [ADDR_W-1:0] wa1,
        input logic [DATA_W-1:0] wd1,
        input logic              we0,
        input logic [ADDR_W-1:0] wa0,
        input logic [DATA_W-1:0] wd0
    );
        if (a == ADDR_W'(PC_REG)) return pc_val;
        if (we1 && (wa1 == a))    return wd1;
        if (we0 && (wa0 == a))    return wd0;
        return stored;
    endfunction

    // Per-entry write decode; the PC entry never matches so it is never written.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int i = 0; i < N_ENT; i++) begin
            if (i != PC_REG) begin
                hit0[i] = bus.we0 && (bus.wa0 == ADDR_W'(i));
                hit1[i] = bus.we1 && (bus.wa1 == ADDR_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENT; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                if (hit1[i])      regs[i] <= bus.wd1;
                else if (hit0[i]) regs[i] <= bus.wd0;
            end
        end
    end

    assign pc_rel = bus.pc_in + DATA_W'(PC_OFFSET);

    always_comb begin
        rd_all = '0;
        for (int k = 0; k < N_RD; k++) begin
            rd_all[k*DATA_W +: DATA_W] = read_port(
                bus.ra[k*ADDR_W +: ADDR_W],
                regs[bus.ra[k*ADDR_W +: ADDR_W]],
                pc_rel,
                bus.we1, bus.wa1, bus.wd1,
                bus.we0, bus.wa0, bus.wd0);
        end
    end

    assign bus.rd = rd_all;

    assign pc_hit0   = bus.we0 && (bus.wa0 == ADDR_W'(PC_REG));
    assign pc_hit1   = bus.we1 && (bus.wa1 == ADDR_W'(PC_REG));
    assign bus.pc_wr = pc_hit1 | pc_hit0;
    assign bus.pc_wd = pc_hit1 ? bus.wd1 : bus.wd0;

    // N,Z and C,V halves load independently; flags are never forwarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz <= '0;
            cv <= '0;
        end else begin
            if (bus.flag_we[1]) nz <= bus.flags_in[3:2];
            if (bus.flag_we[0]) cv <= bus.flags_in[1:0];
        end
    end

    assign bus.flags = {nz, cv};
endmodule

// File: tb/tb_arm_regfile_mp.sv
// Bench for arm_regfile_mp: two configurations (32b/16-entry/3 ports and 16b/8-entry/4 ports),
// table-driven vectors through a scoreboard queue plus hand-written reset sequences.
module tb_arm_regfile_mp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_regfile_mp_if #(.DATA_W(32), .ADDR_W(4), .N_RD(3)) bus_a ();
    arm_regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .N_RD(4)) bus_b ();

    arm_regfile_mp #(.DATA_W(32), .ADDR_W(4), .N_RD(3), .PC_REG(15), .PC_OFFSET(8)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    arm_regfile_mp #(.DATA_W(16), .ADDR_W(3), .N_RD(4), .PC_REG(7), .PC_OFFSET(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    typedef struct packed {
        logic [15:0]      ra;     // port k address in ra[k*4 +: 4]
        logic             we0;
        logic [3:0]       wa0;
        logic [31:0]      wd0;
        logic             we1;
        logic [3:0]       wa1;
        logic [31:0]      wd1;
        logic [31:0]      pc;
        logic [1:0]       fwe;
        logic [3:0]       fin;
        logic [3:0][31:0] erd;
        logic             epcw;
        logic [31:0]      epcwd;
        logic [3:0]       efl;    // stored flags before the edge that ends this cycle
    } vec_t;

    typedef struct {
        int               d;
        string            nm;
        logic [3:0][31:0] rd;
        logic [3:0]       mask;
        logic             pcw;
        logic [31:0]      pcwd;
        logic [3:0]       fl;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    vec_t ta [17];
    vec_t tv [16];

    function automatic vec_t mk(
        input logic [31:0] ra, we0, wa0, wd0, we1, wa1, wd1, pc, fwe, fin,
        input logic [31:0] e0, e1, e2, e3, pcw, pcwd, fl);
        vec_t v;
        v.ra = ra[15:0];   v.we0 = we0[0]; v.wa0 = wa0[3:0]; v.wd0 = wd0;
        v.we1 = we1[0];    v.wa1 = wa1[3:0]; v.wd1 = wd1;    v.pc = pc;
        v.fwe = fwe[1:0];  v.fin = fin[3:0];
        v.erd[0] = e0; v.erd[1] = e1; v.erd[2] = e2; v.erd[3] = e3;
        v.epcw = pcw[0];   v.epcwd = pcwd; v.efl = fl[3:0];
        return v;
    endfunction

    task automatic drive(input int d, input vec_t v);
        if (d == 0) begin
            bus_a.ra = v.ra[11:0];
            bus_a.we0 = v.we0; bus_a.wa0 = v.wa0; bus_a.wd0 = v.wd0;
            bus_a.we1 = v.we1; bus_a.wa1 = v.wa1; bus_a.wd1 = v.wd1;
            bus_a.pc_in = v.pc; bus_a.flag_we = v.fwe; bus_a.flags_in = v.fin;
        end else begin
            for (int k = 0; k < 4; k++) bus_b.ra[k*3 +: 3] = v.ra[k*4 +: 3];
            bus_b.we0 = v.we0; bus_b.wa0 = v.wa0[2:0]; bus_b.wd0 = v.wd0[15:0];
            bus_b.we1 = v.we1; bus_b.wa1 = v.wa1[2:0]; bus_b.wd1 = v.wd1[15:0];
            bus_b.pc_in = v.pc[15:0]; bus_b.flag_we = v.fwe; bus_b.flags_in = v.fin;
        end
    endtask

    task automatic expect_v(input int d, input string nm, input vec_t v);
        exp_t e;
        e.d = d; e.nm = nm; e.rd = v.erd;
        e.mask = (d == 0) ? 4'h7 : 4'hF;
        e.pcw = v.epcw; e.pcwd = v.epcwd; e.fl = v.efl;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        logic [31:0] act;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue want an entry");
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            if (e.mask[k]) begin
                if (e.d == 0) act = bus_a.rd[k*32 +: 32];
                else          act = {16'h0, bus_b.rd[k*16 +: 16]};
                cmp($sformatf("%s.rd%0d", e.nm, k), act, e.rd[k]);
            end
        end
        act = (e.d == 0) ? {31'h0, bus_a.pc_wr} : {31'h0, bus_b.pc_wr};
        cmp($sformatf("%s.pc_wr", e.nm), act, {31'h0, e.pcw});
        act = (e.d == 0) ? bus_a.pc_wd : {16'h0, bus_b.pc_wd};
        cmp($sformatf("%s.pc_wd", e.nm), act, e.pcwd);
        act = (e.d == 0) ? {28'h0, bus_a.flags} : {28'h0, bus_b.flags};
        cmp($sformatf("%s.flags", e.nm), act, {28'h0, e.fl});
    endtask

    task automatic step(input int d, input string nm, input vec_t v);
        drive(d, v);
        expect_v(d, nm, v);
        #1 check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0);

        // Config A: 32-bit data, 16 entries, 3 read ports, PC_REG=15, offset 8.
        ta[0]  = mk('h0210, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0);
        ta[1]  = mk('h0032, 1,2,'h12345678, 0,0,0, 0, 0,0, 'h12345678,0,0,0, 0,'h12345678, 0);
        ta[2]  = mk('h0222, 0,0,0, 0,0,0, 0, 0,0, 'h12345678,'h12345678,'h12345678,0, 0,0, 0);
        ta[3]  = mk('h0125, 1,5,'hAAAA0000, 1,5,'h0000BBBB, 0, 0,0,
                    'h0000BBBB,'h12345678,0,0, 0,'hAAAA0000, 0);
        ta[4]  = mk('h0255, 0,0,0, 0,0,0, 0, 0,0, 'h0000BBBB,'h0000BBBB,'h12345678,0, 0,0, 0);
        ta[5]  = mk('h0756, 1,6,'h66666666, 1,5,'h11111111, 0, 0,0,
                    'h66666666,'h11111111,0,0, 0,'h66666666, 0);
        ta[6]  = mk('h0F56, 0,0,0, 0,0,0, 'h100, 0,0, 'h66666666,'h11111111,'h108,0, 0,0, 0);
        ta[7]  = mk('h0FFF, 1,15,'h200, 0,0,0, 'hFFFFFFFC, 0,0, 4,4,4,0, 1,'h200, 0);
        ta[8]  = mk('h0520, 1,15,'h200, 1,15,'h300, 0, 0,0, 0,'h12345678,'h11111111,0, 1,'h300, 0);
        ta[9]  = mk('h0624, 1,15,'h500, 1,4,'h44, 'h10, 0,0, 'h44,'h12345678,'h66666666,0, 1,'h500, 0);
        ta[10] = mk('h0F54, 0,0,0, 0,0,0, 'h10, 0,0, 'h44,'h11111111,'h18,0, 0,0, 0);
        ta[11] = mk(0, 0,0,0, 0,0,0, 0, 2,'hF, 0,0,0,0, 0,0, 'h0);
        ta[12] = mk(0, 0,0,0, 0,0,0, 0, 1,'h3, 0,0,0,0, 0,0, 'hC);
        ta[13] = mk(0, 0,0,0, 0,0,0, 0, 0,'h0, 0,0,0,0, 0,0, 'hF);
        ta[14] = mk(0, 0,0,0, 0,0,0, 0, 0,'h5, 0,0,0,0, 0,0, 'hF);
        ta[15] = mk(0, 0,0,0, 0,0,0, 0, 3,'h0, 0,0,0,0, 0,0, 'hF);
        ta[16] = mk(0, 0,0,0, 0,0,0, 0, 0,'h0, 0,0,0,0, 0,0, 'h0);

        // Config B: 16-bit data, 8 entries, 4 read ports, PC_REG=7, offset 4.
        tv[0]  = mk('h3210, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0);
        tv[1]  = mk('h1032, 1,2,'h1234, 0,0,0, 0, 0,0, 'h1234,0,0,0, 0,'h1234, 0);
        tv[2]  = mk('h2222, 0,0,0, 0,0,0, 0, 0,0, 'h1234,'h1234,'h1234,'h1234, 0,0, 0);
        tv[3]  = mk('h5125, 1,5,'hAA00, 1,5,'h00BB, 0, 0,0, 'h00BB,'h1234,0,'h00BB, 0,'hAA00, 0);
        tv[4]  = mk('h5255, 0,0,0, 0,0,0, 0, 0,0, 'h00BB,'h00BB,'h1234,'h00BB, 0,0, 0);
        tv[5]  = mk('h2757, 0,0,0, 0,0,0, 'h100, 0,0, 'h0104,'h00BB,'h0104,'h1234, 0,0, 0);
        tv[6]  = mk('h7777, 1,7,'h200, 0,0,0, 'hFFFE, 0,0, 2,2,2,2, 1,'h200, 0);
        tv[7]  = mk('h6520, 1,7,'h200, 1,7,'h300, 0, 0,0, 0,'h1234,'h00BB,0, 1,'h300, 0);
        tv[8]  = mk('h7254, 1,7,'h500, 1,4,'h44, 'h10, 0,0, 'h44,'h00BB,'h1234,'h14, 1,'h500, 0);
        tv[9]  = mk('h1364, 0,0,0, 0,0,0, 0, 0,0, 'h44,0,0,0, 0,0, 0);
        tv[10] = mk(0, 0,0,0, 0,0,0, 0, 2,'hF, 0,0,0,0, 0,0, 'h0);
        tv[11] = mk(0, 0,0,0, 0,0,0, 0, 1,'h3, 0,0,0,0, 0,0, 'hC);
        tv[12] = mk(0, 0,0,0, 0,0,0, 0, 0,'h0, 0,0,0,0, 0,0, 'hF);
        tv[13] = mk(0, 0,0,0, 0,0,0, 0, 0,'hA, 0,0,0,0, 0,0, 'hF);
        tv[14] = mk(0, 0,0,0, 0,0,0, 0, 3,'h0, 0,0,0,0, 0,0, 'hF);
        tv[15] = mk(0, 0,0,0, 0,0,0, 0, 0,'h0, 0,0,0,0, 0,0, 'h0);

        reset = 1'b1;
        drive(0, idle);
        drive(1, idle);
        #2 reset = 1'b0;
        expect_v(0, "rst_a", idle);
        expect_v(1, "rst_b", idle);
        #1 check_pop();
        check_pop();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            step(0, $sformatf("A%0d", i), ta[i]);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            step(1, $sformatf("B%0d", i), tv[i]);
        end

        // Async reset between edges wipes storage and flags with no clock.
        @(negedge clk);
        drive(0, mk(0, 1,3,'hDEADBEEF, 0,0,0, 0, 3,'hA, 0,0,0,0, 0,0, 0));
        drive(1, mk(0, 1,3,'hBEEF, 0,0,0, 0, 3,'hA, 0,0,0,0, 0,0, 0));
        @(negedge clk);
        step(0, "pre_rst_a", mk('h0003, 0,0,0, 0,0,0, 0, 0,0, 'hDEADBEEF,0,0,0, 0,0, 'hA));
        step(1, "pre_rst_b", mk('h0003, 0,0,0, 0,0,0, 0, 0,0, 'hBEEF,0,0,0, 0,0, 'hA));
        #1 reset = 1'b0;
        #1;
        expect_v(0, "rst_clr_a", mk('h0003, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0));
        expect_v(1, "rst_clr_b", mk('h0003, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0));
        check_pop();
        check_pop();
        #1 reset = 1'b1;

        // Write during reset: forwarded combinationally, never committed.
        @(negedge clk);
        reset = 1'b0;
        step(0, "rst_wr_a", mk('h0004, 1,4,'h4444, 0,0,0, 0, 3,'hF, 'h4444,0,0,0, 0,'h4444, 0));
        step(1, "rst_wr_b", mk('h0004, 1,4,'h4444, 0,0,0, 0, 3,'hF, 'h4444,0,0,0, 0,'h4444, 0));
        @(negedge clk);
        reset = 1'b1;
        step(0, "rst_lost_a", mk('h0004, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0));
        step(1, "rst_lost_b", mk('h0004, 0,0,0, 0,0,0, 0, 0,0, 0,0,0,0, 0,0, 0));
        @(negedge clk);
        step(0, "resume_fw_a", mk('h0004, 1,4,'h77, 0,0,0, 0, 0,0, 'h77,0,0,0, 0,'h77, 0));
        step(1, "resume_fw_b", mk('h0004, 1,4,'h77, 0,0,0, 0, 0,0, 'h77,0,0,0, 0,'h77, 0));
        @(negedge clk);
        step(0, "resume_rd_a", mk('h0004, 0,0,0, 0,0,0, 0, 0,0, 'h77,0,0,0, 0,0, 0));
        step(1, "resume_rd_b", mk('h0004, 0,0,0, 0,0,0, 0, 0,0, 'h77,0,0,0, 0,0, 0));

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arm_regfile_mp.md
# arm_regfile_mp

Parametrised multi-port register file with bypassing and flag storage for the ARM datapath. It replaces the fixed 2-read/1-write register file. It adds the following:
- a configurable number of read ports;
- a second write port for base-register writeback;
- write-first forwarding;
- PC-relative reads of the PC register;
- a separately enabled NZCV flag register.

It sits between the decode/control unit and the ALU. It is the state-holding core of the datapath.

## Interface
Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 4, register address width; the file holds 2**ADDR_W entries
- N_RD, 3, number of read ports (1..4)
- PC_REG, 15, index that aliases the program counter
- PC_OFFSET, 8, value added to pc_in on reads of PC_REG

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- ra  in  N_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd  out  N_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- we0  in  1  write enable, port 0 (result writeback)
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (base writeback)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- pc_in  in  DATA_W  current PC
- pc_wr  out  1  asserted when an enabled write targets PC_REG
- pc_wd  out  DATA_W  data of that PC write
- flag_we  in  2  bit 1 enables the N,Z update; bit 0 enables the C,V update
- flags_in  in  4  NZCV from the ALU, N in bit 3
- flags  out  4  stored NZCV

## Operation
- **Storage.** Entries 0..2**ADDR_W-1 are flip-flops, except PC_REG. Entry PC_REG is not stored.
- **Reads (combinational).** For each port k, resolve rd_k in priority order:
  - ra_k == PC_REG: rd_k = pc_in + PC_OFFSET, modulo 2**DATA_W.
  - else, we1 && wa1 == ra_k: rd_k = wd1 (forwarded).
  - else, we0 && wa0 == ra_k: rd_k = wd0 (forwarded).
  - else: rd_k = stored entry.
- **Writes.** On a rising edge:
  - an enabled port whose address is not PC_REG writes its data;
  - if we0 and we1 target the same address, port 1 wins;
  - writes to PC_REG never touch storage.
- **PC redirect.**
  - pc_wr = (we1 && wa1 == PC_REG) || (we0 && wa0 == PC_REG).
  - pc_wd = wd1 if port 1 targets PC_REG, else wd0.
  - Both outputs are combinational; the PC logic consumes them.
- **Flags.** On a rising edge:
  - flag_we[1] loads flags[3:2] from flags_in[3:2];
  - flag_we[0] loads flags[1:0] from flags_in[1:0];
  - the two halves update independently;
  - flags is not forwarded: it shows the stored value only.
- **Out-of-range parameters.** N_RD outside 1..4, or PC_REG >= 2**ADDR_W, is an elaboration error.

## Timing
- **Reset.** reset low asynchronously clears every stored entry and flags to 0. The effect is immediate, with no clock edge.
  - During reset, rd shows 0 for non-PC addresses unless a write is being forwarded.
  - Forwarding stays combinational during reset, but no write commits while reset is low.
- **Reset release.** Writes resume on the first rising edge with reset high.
- **Reset mid-write.** If reset falls in the same cycle as a write, the write is lost.
- **Write latency.** A value written at edge n is read from storage from edge n onward. In the cycle before edge n it is visible through forwarding (zero-cycle read-after-write).
- **Read latency.** 0 cycles: purely combinational from ra, wa*, we*, wd*, pc_in.
- **Flag latency.** 1 cycle: flags reflects flags_in after the enabled edge.

## Test plan
- **Reset clear.** Write 0xDEADBEEF to r3, then pulse reset low between edges with no clock. Required: rd for r3 = 0 immediately and flags = 0000.
- **Write then read.** we0=1, wa0=2, wd0=0x12345678 for one edge, then ra port0=2 with we0=0. Required: rd0 = 0x12345678. Also read r2 on ports 1 and 2 at the same time; both must return the same value.
- **Forwarding and port priority.** Same cycle: we0=1, wa0=5, wd0=0xAAAA0000 and we1=1, wa1=5, wd1=0x0000BBBB, with ra0=5. Required:
  - before the edge, rd0 = 0x0000BBBB;
  - after the edge with both write enables low, rd0 = 0x0000BBBB.
- **PC alias.** pc_in=0x00000100, ra1=15. Required: rd1 = 0x00000108.
  - With pc_in=0xFFFFFFFC, rd1 = 0x00000004 (wrap).
  - we0=1, wa0=15, wd0=0x200. Required: pc_wr=1, pc_wd=0x200, and storage unchanged.
- **Split flag update.** flags_in=1111, flag_we=10 for one edge. Required: flags=1100.
  - Then flags_in=0011, flag_we=01. Required: flags=1111.
  - Then flag_we=00 with any flags_in. Required: flags unchanged.
- **Parameter sweep.** DATA_W=16, ADDR_W=3, N_RD=4, PC_REG=7, PC_OFFSET=4. Repeat the scenarios above; this checks the flat-bus slicing and the PC read of 0x0104 for pc_in=0x0100.
